// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the control/bus block.
// First-word-fall-through storage with occupancy, sticky overflow and a
// threshold-level interrupt request.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_end,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    input  logic [ADDR_W:0]   thresh,
    output logic              irq_level,
    output logic              ovf,
    input  logic              ovf_clr,
    input  logic              flush
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_irq;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_irq_nxt;

    // Status decode and accept/drop qualification from registered occupancy
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(DEPTH));
        w_pop   = pop && !w_empty;
        w_push  = rx_end && (!w_full || w_pop);
        w_drop  = rx_end && w_full && !w_pop;
    end

    // Next occupancy and the interrupt level that goes with it
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
        w_irq_nxt = (thresh != '0) && (w_count_nxt >= thresh);
    end

    // Pointers, occupancy, overflow flag and interrupt level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_irq   <= w_irq_nxt;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
            end
            // A drop outranks a clear in the same cycle; flush never drops
            if (w_drop && !flush) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage array; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    assign rd_data   = r_mem[r_rd_ptr];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign irq_level = r_irq;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued as they are
// driven and compared against rd_data when they reach the head / are popped.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              rx_end;
    logic [DATA_W-1:0] rx_data;
    logic              pop;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   thresh;
    logic              irq_level;
    logic              ovf;
    logic              ovf_clr;
    logic              flush;

    int unsigned n_cmp;
    int unsigned n_err;

    logic [DATA_W-1:0] sb_q[$];
    logic              m_ovf;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_end    (rx_end),
        .rx_data   (rx_data),
        .pop       (pop),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .thresh    (thresh),
        .irq_level (irq_level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .flush     (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check all status outputs against the bench model
    task automatic chk_status(input string tag);
        int unsigned sz;
        logic        exp_irq;
        sz      = sb_q.size();
        exp_irq = (thresh != 0) && (sz >= int'(thresh));
        chk({tag, ".count"}, 32'(count), 32'(sz));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".full"},  32'(full),  32'(sz == DEPTH));
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        chk({tag, ".irq"},   32'(irq_level), 32'(exp_irq));
        if (sz != 0) begin
            chk({tag, ".head"}, 32'(rd_data), 32'(sb_q[0]));
        end
    endtask

    // One clock cycle: drive inputs, update model, advance, check
    task automatic cyc(input string tag, input logic re, input logic [7:0] d,
                       input logic p, input logic fl, input logic oc);
        logic pop_ok;
        logic push_ok;
        logic drop;
        rx_end  = re;
        rx_data = d;
        pop     = p;
        flush   = fl;
        ovf_clr = oc;
        pop_ok  = p && (sb_q.size() != 0);
        push_ok = re && ((sb_q.size() < DEPTH) || pop_ok);
        drop    = re && (sb_q.size() == DEPTH) && !pop_ok;
        if (pop_ok && !fl) begin
            chk({tag, ".pop_data"}, 32'(rd_data), 32'(sb_q[0]));
        end
        if (fl) begin
            sb_q.delete();
        end else begin
            if (pop_ok) void'(sb_q.pop_front());
            if (push_ok) sb_q.push_back(d);
        end
        if (drop && !fl) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rx_end  = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        ovf_clr = 1'b0;
        chk_status(tag);
    endtask

    task automatic do_reset(input string tag, input logic re);
        reset  = 1'b1;
        rx_end = re;
        rx_data = 8'hEE;
        pop    = re;
        flush  = re;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        rx_end = 1'b0;
        pop    = 1'b0;
        flush  = 1'b0;
        sb_q.delete();
        m_ovf = 1'b0;
        chk_status(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_ovf = 1'b0;
        reset = 1'b1;
        rx_end = 1'b0;
        rx_data = '0;
        pop = 1'b0;
        thresh = '0;
        ovf_clr = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        do_reset("reset", 1'b0);
        cyc("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Single byte round trip
        cyc("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cyc("pop_a5",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill, overflow drop, drain
        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cyc("drop_ff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Pointer wrap with streaming push/pop pairs
        cyc("wrap_pre", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc("wrap_pair", 1'b1, 8'(8'h81 + i), 1'b1, 1'b0, 1'b0);
        cyc("wrap_post", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Full + push + pop: no overflow, 0x55 read last
        cyc("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cyc("full_pp", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Empty + push + pop: pop ignored
        cyc("empty_pp", 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        cyc("pop_33",   1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Drop racing ovf_clr: set wins; then clear alone
        for (int i = 0; i < 16; i++) cyc("fill3", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        cyc("drop_clr", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        cyc("clr_only", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc("drain3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Threshold interrupt
        thresh = 5'd4;
        for (int i = 0; i < 4; i++) cyc("thr_push", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cyc("thr_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        thresh = 5'd17;
        for (int i = 0; i < 13; i++) cyc("thr17", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        thresh = 5'd0;
        cyc("thr0_full", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        thresh = 5'd16;
        cyc("thr16", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        thresh = 5'd0;

        // Flush with ovf set and a coincident push
        cyc("drop2", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc("to5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc("flush", 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        cyc("after_flush", 1'b1, 8'h67, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a receive stream
        thresh = 5'd1;
        for (int i = 0; i < 3; i++) cyc("stream", 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        do_reset("mid_reset", 1'b1);
        cyc("post_reset", 1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        cyc("post_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver and the UART control/bus block. Captures every byte the receiver completes (one-cycle rx_end strobe plus rx_data), holds up to DEPTH bytes in first-word-fall-through order, and presents them to the control block for CPU reads. Provides occupancy, a sticky overflow flag and a threshold-level interrupt request so the CPU is not interrupted on every byte.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
ADDR_W, 4, pointer width, log2(DEPTH)
DATA_W, 8, entry width; matches the byte data bus

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rx_end  in  1  one-cycle strobe from receiver: rx_data holds a completed byte
rx_data  in  DATA_W  received byte, sampled when rx_end=1
pop  in  1  consumer removes head entry this cycle
rd_data  out  DATA_W  head entry; valid only while empty=0
empty  out  1  no entries held
full  out  1  DEPTH entries held
count  out  ADDR_W+1  current occupancy, 0..DEPTH
thresh  in  ADDR_W+1  interrupt level, 0 disables
irq_level  out  1  count >= thresh with thresh != 0
ovf  out  1  sticky: at least one byte dropped since last clear
ovf_clr  in  1  clears ovf
flush  in  1  discards all entries

Behaviour:
- Reset (reset=1 at clk edge): wr_ptr=0, rd_ptr=0, count=0, ovf=0; outputs empty=1, full=0, irq_level=0. rd_data is don't-care while empty. Storage array is not cleared.
- Storage: DEPTH x DATA_W register array; wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0 naturally. count is kept as a separate register. empty=(count==0), full=(count==DEPTH), both decoded from registered count.
- Push: accepted when rx_end=1 and (full=0 or pop accepted same cycle). Writes mem[wr_ptr]<=rx_data, wr_ptr+1.
- Pop: accepted when pop=1 and empty=0. rd_ptr+1. pop while empty is ignored: no pointer or count change, no error flag.
- count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- Latency: a byte pushed at edge N is visible on rd_data, with empty=0 and count updated, after edge N (cycle N+1). A push into an empty FIFO with pop=1 in the same cycle: pop ignored, since empty=1 at that edge.
- rd_data = mem[rd_ptr] (FWFT). After a pop, the next entry appears in the following cycle.
- Full + rx_end + accepted pop: both accepted, count stays DEPTH, no overflow.
- Full + rx_end, no pop: byte dropped, pointers unchanged, ovf<=1.
- ovf: set on a drop, cleared by ovf_clr. A drop and ovf_clr in the same cycle leaves ovf=1 (set wins). ovf is not affected by flush.
- flush: highest priority after reset. wr_ptr, rd_ptr and count <= 0. Any push or pop in the same cycle is discarded and does not set ovf.
- irq_level: registered, equal to (next_count >= thresh) && (thresh != 0). It is aligned with count, so it asserts in the same cycle count reaches the threshold. Level signal: deasserts once pops bring count below thresh. thresh > DEPTH never asserts. thresh may change at any time, and the new value takes effect at the next edge.
- Reset asserted mid-stream: all state returns to reset values at that edge, regardless of rx_end, pop or flush.

Test Plan:
- Reset then idle: empty=1, full=0, count=0, ovf=0, irq_level=0. Push 0xA5 -> next cycle empty=0, count=1, rd_data=0xA5. Pop -> next cycle empty=1, count=0.
- Fill (DEPTH=16): push 0x00..0x0F -> full=1, count=16. Push 0xFF -> ovf=1, count=16. Pop 16 times -> rd_data sequence 0x00..0x0F, 0xFF never appears, then empty=1. Pointers wrap; continue with 20 more push/pop pairs and check ordering.
- Simultaneous events: at full, push 0x55 and pop in the same cycle -> count=16, ovf=0, 0x55 is read last. At empty, push 0x33 and pop in the same cycle -> count=1, rd_data=0x33. Pop at empty -> no change.
- Overflow clear race: force a drop and ovf_clr in the same cycle -> ovf=1. ovf_clr alone next cycle -> ovf=0.
- Threshold: thresh=4, push 3 bytes -> irq_level=0. Fourth push -> irq_level=1 in the same cycle count=4. Pop one -> irq_level=0. thresh=0 with 16 entries -> irq_level=0.
- Flush and reset: with 5 entries held and ovf=1, assert flush together with rx_end -> count=0, empty=1, ovf=1. Reset asserted during a stream of rx_end -> all outputs return to reset values on that edge.
